level_round_ctrl: RTL

Parametrised game-round controller for the binary-equivalent game. It replaces the fixed per-level countdown counters and the score incrementer with one FSM that handles level progression, countdown reload, guess checking, saturating score and event pulses. It sits between the clock divider (1 Hz tick), the random target generator, the switch/key inputs, the 7-seg/LED display logic and the buzzer effects.

---
 rtl/level_round_pkg.sv | 41 ++++
 rtl/level_round_ctrl_round_timer.sv | 40 ++++
 rtl/level_round_ctrl.sv | 193 +++++++++++++++++++
 3 files changed

// File: rtl/level_round_pkg.sv
// rtl/level_round_pkg.sv - shared types and constant helpers for the game-round controller
//
// Purpose: state encoding plus pure constant functions for per-level round time,
// per-level points, and the configuration legality checks used at elaboration.
// Ports: none (package).
package level_round_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD,
    S_ARM,
    S_PLAY,
    S_OVER,
    S_DONE
  } state_t;

  // Round length for a level: level 1 gets base_time, each further level adds time_step.
  function automatic int level_time(input int lvl, input int base_time, input int time_step);
    return base_time + (lvl - 1) * time_step;
  endfunction

  // Points awarded for one correct guess on a level.
  function automatic int level_points(input int lvl, input int base_points);
    return base_points * lvl;
  endfunction

  function automatic bit levels_ok(input int num_levels);
    return (num_levels >= 1) && (num_levels <= 15);
  endfunction

  // The longest round time must be representable in the countdown register.
  function automatic bit time_fits(input int num_levels, input int base_time,
                                   input int time_step, input int time_w);
    return (base_time + (num_levels - 1) * time_step) < (1 << time_w);
  endfunction

  function automatic bit score_fits(input int score_max, input int score_w);
    return score_max < (1 << score_w);
  endfunction

endpackage

// File: rtl/level_round_ctrl_round_timer.sv
// rtl/level_round_ctrl_round_timer.sv - loadable saturating countdown for the round time
//
// Purpose: holds the remaining round time; load wins over decrement, decrements
// saturate at zero.
// Ports:
//   clk, reset      clock, asynchronous active-low reset
//   load, load_val  reload the count
//   dec_en, dec_amt subtract dec_amt (saturating)
//   count           current remaining ticks
//   zero            high when subtracting dec_amt now would leave the count at zero
import level_round_pkg::*;

module round_timer #(
  parameter int TIME_W = 7
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              load,
  input  logic [TIME_W-1:0] load_val,
  input  logic              dec_en,
  input  logic [TIME_W-1:0] dec_amt,
  output logic [TIME_W-1:0] count,
  output logic              zero
);

  // Looks ahead at the pending decrement so the controller can raise its lose
  // event in the same cycle the count lands on zero.
  assign zero = (count <= dec_amt);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      count <= '0;
    end else if (load) begin
      count <= load_val;
    end else if (dec_en) begin
      count <= zero ? '0 : (count - dec_amt);
    end
  end

endmodule

// File: rtl/level_round_ctrl.sv
// rtl/level_round_ctrl.sv - game-round FSM: levels, countdown, guess check, score, events
//
// Purpose: sequences IDLE -> LOAD -> ARM -> PLAY and the OVER/DONE end states,
// reloads the round timer per level, checks guesses, keeps a saturating score and
// emits one-cycle registered event pulses.
// Ports:
//   clk, reset                     clock, asynchronous active-low reset
//   tick, start, submit            one-cycle input pulses
//   guess, target                  switch value and generator value
//   target_req                     one-cycle request for a new target (during LOAD)
//   time_left, score, level        game status
//   playing                        high in ARM/PLAY
//   correct_p, wrong_p, lose_p, win_p  registered event pulses
import level_round_pkg::*;

module level_round_ctrl #(
  parameter int NUM_LEVELS       = 3,
  parameter int VAL_W            = 8,
  parameter int TIME_W           = 7,
  parameter int SCORE_W          = 14,
  parameter int BASE_TIME        = 30,
  parameter int TIME_STEP        = 10,
  parameter int BASE_POINTS      = 100,
  parameter int ROUNDS_PER_LEVEL = 3,
  parameter int WRONG_PENALTY    = 5,
  parameter int SCORE_MAX        = 9999
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               tick,
  input  logic               start,
  input  logic               submit,
  input  logic [VAL_W-1:0]   guess,
  input  logic [VAL_W-1:0]   target,
  output logic               target_req,
  output logic [TIME_W-1:0]  time_left,
  output logic [SCORE_W-1:0] score,
  output logic [3:0]         level,
  output logic               playing,
  output logic               correct_p,
  output logic               wrong_p,
  output logic               lose_p,
  output logic               win_p
);

  if (!levels_ok(NUM_LEVELS)) begin : g_bad_levels
    $error("level_round_ctrl: NUM_LEVELS must be in 1..15");
  end
  if (!time_fits(NUM_LEVELS, BASE_TIME, TIME_STEP, TIME_W)) begin : g_bad_time
    $error("level_round_ctrl: longest round time does not fit in TIME_W");
  end
  if (!score_fits(SCORE_MAX, SCORE_W)) begin : g_bad_score
    $error("level_round_ctrl: SCORE_MAX does not fit in SCORE_W");
  end

  localparam int RC_W = (ROUNDS_PER_LEVEL > 1) ? $clog2(ROUNDS_PER_LEVEL) : 1;
  localparam int SW1  = SCORE_W + 1;

  state_t             state, state_nxt;
  logic [RC_W-1:0]    round_cnt, round_nxt;
  logic [VAL_W-1:0]   target_q;
  logic [SCORE_W-1:0] score_nxt, score_cap;
  logic [SCORE_W:0]   score_sum;
  logic [3:0]         level_nxt;
  logic               correct_nxt, wrong_nxt, lose_nxt, win_nxt;
  logic               restart;
  logic               t_load, t_dec_en, t_zero;
  logic [TIME_W-1:0]  t_load_val, t_dec_amt;
  logic               match, last_round, top_level;

  assign match      = (guess == target_q);
  assign last_round = (round_cnt == RC_W'(ROUNDS_PER_LEVEL - 1));
  assign top_level  = (level == 4'(NUM_LEVELS));

  // One extra bit so the sum cannot wrap before it is clamped.
  assign score_sum  = {1'b0, score} + SW1'(level_points(int'(level), BASE_POINTS));
  assign score_cap  = (score_sum > SW1'(SCORE_MAX)) ? SCORE_W'(SCORE_MAX)
                                                    : score_sum[SCORE_W-1:0];
  assign t_load_val = TIME_W'(level_time(int'(level), BASE_TIME, TIME_STEP));

  round_timer #(.TIME_W(TIME_W)) u_timer (
    .clk      (clk),
    .reset    (reset),
    .load     (t_load),
    .load_val (t_load_val),
    .dec_en   (t_dec_en),
    .dec_amt  (t_dec_amt),
    .count    (time_left),
    .zero     (t_zero)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= S_IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE: if (start) state_nxt = S_LOAD;
      S_LOAD: state_nxt = S_ARM;
      S_ARM:  state_nxt = start ? S_LOAD : S_PLAY;
      S_PLAY: begin
        if (start) begin
          state_nxt = S_LOAD;
        end else if (submit) begin
          if (match)       state_nxt = (last_round && top_level) ? S_DONE : S_LOAD;
          else if (t_zero) state_nxt = S_OVER;
        end else if (tick && t_zero) begin
          state_nxt = S_OVER;
        end
      end
      S_OVER, S_DONE: if (start) state_nxt = S_LOAD;
      default: state_nxt = S_IDLE;
    endcase
  end

  always_comb begin
    score_nxt   = score;
    level_nxt   = level;
    round_nxt   = round_cnt;
    correct_nxt = 1'b0;
    wrong_nxt   = 1'b0;
    lose_nxt    = 1'b0;
    win_nxt     = 1'b0;
    restart     = 1'b0;
    t_load      = 1'b0;
    t_dec_en    = 1'b0;
    t_dec_amt   = TIME_W'(1);
    target_req  = (state == S_LOAD);
    playing     = (state == S_ARM) || (state == S_PLAY);
    case (state)
      S_LOAD: t_load = 1'b1;
      S_ARM, S_OVER, S_DONE: restart = start;
      S_PLAY: begin
        if (start) begin
          restart = 1'b1;
        end else if (submit) begin
          if (match) begin
            // A tick arriving with a correct guess is dropped: the timer reloads anyway.
            correct_nxt = 1'b1;
            score_nxt   = score_cap;
            if (last_round) begin
              round_nxt = '0;
              if (top_level) win_nxt = 1'b1;
              else           level_nxt = level + 4'd1;
            end else begin
              round_nxt = round_cnt + RC_W'(1);
            end
          end else begin
            // A coincident tick is folded into the penalty rather than lost.
            wrong_nxt = 1'b1;
            t_dec_en  = 1'b1;
            t_dec_amt = TIME_W'(WRONG_PENALTY) + TIME_W'(tick);
            lose_nxt  = t_zero;
          end
        end else if (tick) begin
          t_dec_en = 1'b1;
          lose_nxt = t_zero;
        end
      end
      default: ;
    endcase
    if (restart) begin
      score_nxt = '0;
      level_nxt = 4'd1;
      round_nxt = '0;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      score     <= '0;
      level     <= 4'd1;
      round_cnt <= '0;
      target_q  <= '0;
      correct_p <= 1'b0;
      wrong_p   <= 1'b0;
      lose_p    <= 1'b0;
      win_p     <= 1'b0;
    end else begin
      score     <= score_nxt;
      level     <= level_nxt;
      round_cnt <= round_nxt;
      correct_p <= correct_nxt;
      wrong_p   <= wrong_nxt;
      lose_p    <= lose_nxt;
      win_p     <= win_nxt;
      if (state == S_ARM) target_q <= target;
    end
  end

endmodule
